// File: rtl/pe_kl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_kl_pkg                                                          |
// | Shared types for the PE key-lock dispatcher.                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pe_kl_pkg;

  localparam int KL_ROW_W = 2;
  localparam int KL_COL_W = 2;
  localparam int KL_LEN_W = 8;

  typedef struct packed {
    logic [KL_ROW_W-1:0] row;
    logic [KL_COL_W-1:0] col;
  } kl_tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MATCH  = 2'd1,
    ACTIVE = 2'd2
  } kl_state_e;

  // Default-width key bundle (tag, wildcard mask, activation length)
  typedef struct packed {
    kl_tag_t             tag;
    kl_tag_t             mask;
    logic [KL_LEN_W-1:0] len;
  } kl_key_t;

endpackage
`default_nettype wire

// File: rtl/pe_kl_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_kl_entry                                                        |
// | One lock-table entry: valid + {row,col} tag and masked comparator. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pe_kl_entry #(
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] key_row,
  input  logic [COL_W-1:0] key_col,
  input  logic [ROW_W-1:0] key_mrow,
  input  logic [COL_W-1:0] key_mcol,
  output logic             hit
);

  logic             r_vld;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_row <= '0;
      r_col <= '0;
    end else if (clr) begin
      r_vld <= 1'b0;
    end else if (we) begin
      r_vld <= 1'b1;
      r_row <= wr_row;
      r_col <= wr_col;
    end
  end

  // Masked bits (mask=1) are excluded from the equality test
  assign hit = r_vld
             && (((r_row ^ key_row) & ~key_mrow) == '0)
             && (((r_col ^ key_col) & ~key_mcol) == '0);

endmodule
`default_nettype wire

// File: rtl/pe_kl_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_kl_dispatcher                                                   |
// | Key-lock activation controller driving per-PE enables.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pe_kl_dispatcher
  import pe_kl_pkg::*;
#(
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2,
  parameter int NUM_PE = 16,
  parameter int LEN_W  = 8,
  parameter int IDX_W  = $clog2(NUM_PE),
  parameter int CNT_W  = $clog2(NUM_PE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ROW_W-1:0]  cfg_row,
  input  logic [COL_W-1:0]  cfg_col,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [ROW_W-1:0]  key_row,
  input  logic [COL_W-1:0]  key_col,
  input  logic [ROW_W-1:0]  key_mrow,
  input  logic [COL_W-1:0]  key_mcol,
  input  logic [LEN_W-1:0]  key_len,
  output logic [NUM_PE-1:0] pe_en,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              miss,
  output logic              done,
  output logic              busy
);

  kl_state_e         r_state;
  logic [ROW_W-1:0]  r_key_row;
  logic [COL_W-1:0]  r_key_col;
  logic [ROW_W-1:0]  r_key_mrow;
  logic [COL_W-1:0]  r_key_mcol;
  logic [LEN_W-1:0]  r_key_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [NUM_PE-1:0] w_hit;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cfg_fire;
  logic              w_key_fire;

  assign cfg_ready  = (r_state == IDLE) && !clr;
  assign key_ready  = (r_state == IDLE) && !cfg_valid && !clr;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_key_fire = key_valid && key_ready;
  assign busy       = (r_state != IDLE);

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_entry
    logic w_we;
    assign w_we = w_cfg_fire && (cfg_idx == IDX_W'(gi));

    pe_kl_entry #(
      .ROW_W (ROW_W),
      .COL_W (COL_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (w_we),
      .wr_row   (cfg_row),
      .wr_col   (cfg_col),
      .key_row  (r_key_row),
      .key_col  (r_key_col),
      .key_mrow (r_key_mrow),
      .key_mcol (r_key_mcol),
      .hit      (w_hit[gi])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_cnt = w_cnt + CNT_W'(w_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key_row  <= '0;
      r_key_col  <= '0;
      r_key_mrow <= '0;
      r_key_mcol <= '0;
      r_key_len  <= '0;
      r_cnt      <= '0;
      pe_en      <= '0;
      hit_cnt    <= '0;
      miss       <= 1'b0;
      done       <= 1'b0;
    end else begin
      miss <= 1'b0;
      done <= 1'b0;
      if (clr) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        pe_en   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_key_fire) begin
              r_key_row  <= key_row;
              r_key_col  <= key_col;
              r_key_mrow <= key_mrow;
              r_key_mcol <= key_mcol;
              r_key_len  <= key_len;
              r_state    <= MATCH;
            end
          end
          MATCH: begin
            hit_cnt <= w_cnt;
            if (w_cnt == '0) begin
              miss    <= 1'b1;
              done    <= 1'b1;
              r_state <= IDLE;
            end else if (r_key_len == '0) begin
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              // First enable cycle; done already if this is also the last
              pe_en   <= w_hit;
              r_cnt   <= r_key_len;
              done    <= (r_key_len == LEN_W'(1));
              r_state <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (r_cnt == LEN_W'(1)) begin
              pe_en   <= '0;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt - LEN_W'(1);
              done  <= (r_cnt == LEN_W'(2));
            end
          end
          default: begin
            pe_en   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_kl_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pe_kl_dispatcher                                                |
// | Randomized self-checking bench with a lock-table reference model.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pe_kl_dispatcher;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_idx;
  logic [1:0]  cfg_row, cfg_col;
  logic        key_valid, key_ready;
  logic [1:0]  key_row, key_col, key_mrow, key_mcol;
  logic [7:0]  key_len;
  logic [15:0] pe_en;
  logic [4:0]  hit_cnt;
  logic        miss, done, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference lock table
  bit       m_vld [16];
  bit [1:0] m_row [16];
  bit [1:0] m_col [16];

  pe_kl_dispatcher dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_row(cfg_row), .cfg_col(cfg_col),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_row(key_row), .key_col(key_col), .key_mrow(key_mrow), .key_mcol(key_mcol),
    .key_len(key_len),
    .pe_en(pe_en), .hit_cnt(hit_cnt), .miss(miss), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] model_hits(input bit [1:0] r, input bit [1:0] c,
                                             input bit [1:0] mr, input bit [1:0] mc);
    logic [15:0] h;
    bit ok;
    h = '0;
    for (int i = 0; i < 16; i++) begin
      ok = m_vld[i];
      for (int b = 0; b < 2; b++) begin
        if (!mr[b] && (m_row[i][b] != r[b])) ok = 0;
        if (!mc[b] && (m_col[i][b] != c[b])) ok = 0;
      end
      h[i] = ok;
    end
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 0;
  endtask

  // Entry point and exit point of every task: just after a rising edge
  task automatic cfg_write(input int idx, input int r, input int c);
    int guard;
    cfg_valid = 1; cfg_idx = 4'(idx); cfg_row = 2'(r); cfg_col = 2'(c);
    guard = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 300) begin
      @(posedge clk); #1; @(negedge clk); guard++;
    end
    if (guard >= 300) chk("cfg_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 0;
    m_vld[idx] = 1; m_row[idx] = 2'(r); m_col[idx] = 2'(c);
  endtask

  task automatic key_hs(input int r, input int c, input int mr, input int mc, input int len);
    int guard;
    key_valid = 1; key_row = 2'(r); key_col = 2'(c);
    key_mrow = 2'(mr); key_mcol = 2'(mc); key_len = 8'(len);
    guard = 0;
    @(negedge clk);
    while (!key_ready && guard < 300) begin
      @(posedge clk); #1; @(negedge clk); guard++;
    end
    if (guard >= 300) chk("key_timeout", 0, 1);
    @(posedge clk); #1;
    key_valid = 0;
  endtask

  // Called in cycle T+1 after the key handshake edge T
  task automatic expect_key(input logic [15:0] hits, input int len, input string nm);
    int cnt;
    cnt = $countones(hits);
    @(negedge clk);
    chk({nm, "_match_busy"}, busy, 1);
    chk({nm, "_match_pe_en"}, pe_en, 0);
    @(posedge clk); #1;
    if (cnt == 0) begin
      @(negedge clk);
      chk({nm, "_miss"}, miss, 1);
      chk({nm, "_miss_done"}, done, 1);
      chk({nm, "_miss_pe_en"}, pe_en, 0);
      chk({nm, "_miss_cnt"}, hit_cnt, 0);
      chk({nm, "_miss_busy"}, busy, 0);
      @(posedge clk); #1;
    end else if (len == 0) begin
      @(negedge clk);
      chk({nm, "_len0_done"}, done, 1);
      chk({nm, "_len0_miss"}, miss, 0);
      chk({nm, "_len0_pe_en"}, pe_en, 0);
      chk({nm, "_len0_cnt"}, hit_cnt, 32'(cnt));
      chk({nm, "_len0_busy"}, busy, 0);
      @(posedge clk); #1;
    end else begin
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        chk({nm, "_act_pe_en"}, pe_en, 32'(hits));
        chk({nm, "_act_done"}, done, 32'(k == len));
        chk({nm, "_act_miss"}, miss, 0);
        chk({nm, "_act_cnt"}, hit_cnt, 32'(cnt));
        chk({nm, "_act_busy"}, busy, 1);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk({nm, "_end_pe_en"}, pe_en, 0);
    chk({nm, "_end_done"}, done, 0);
    chk({nm, "_end_miss"}, miss, 0);
    chk({nm, "_end_busy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_key(input int r, input int c, input int mr, input int mc,
                         input int len, input string nm);
    logic [15:0] h;
    h = model_hits(2'(r), 2'(c), 2'(mr), 2'(mc));
    key_hs(r, c, mr, mc, len);
    expect_key(h, len, nm);
  endtask

  task automatic program_grid();
    for (int i = 0; i < 16; i++) cfg_write(i, i / 4, i % 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h;
    rst = 1; clr = 0; cfg_valid = 0; key_valid = 0;
    cfg_idx = 0; cfg_row = 0; cfg_col = 0;
    key_row = 0; key_col = 0; key_mrow = 0; key_mcol = 0; key_len = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pe_en", pe_en, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss", miss, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_key_ready", key_ready, 1);
    @(posedge clk); #1;

    // Unprogrammed table misses
    run_key(1, 1, 0, 0, 3, "unprog");

    program_grid();
    run_key(1, 2, 0, 0, 3, "exact");
    run_key(2, 0, 0, 3, 1, "rowbc");
    run_key(0, 0, 3, 3, 2, "wild");
    run_key(3, 1, 3, 0, 0, "len0");
    run_key(0, 1, 1, 2, 255, "lenmax");

    // cfg and key offered in the same idle cycle
    cfg_valid = 1; cfg_idx = 4'd5; cfg_row = 2'd3; cfg_col = 2'd3;
    key_valid = 1; key_row = 2'd3; key_col = 2'd3; key_mrow = 0; key_mcol = 0; key_len = 8'd2;
    @(negedge clk);
    chk("pri_cfg_ready", cfg_ready, 1);
    chk("pri_key_ready", key_ready, 0);
    @(posedge clk); #1;
    cfg_valid = 0;
    m_vld[5] = 1; m_row[5] = 2'd3; m_col[5] = 2'd3;
    @(negedge clk);
    chk("pri_key_ready_next", key_ready, 1);
    @(posedge clk); #1;
    key_valid = 0;
    h = model_hits(2'd3, 2'd3, 2'd0, 2'd0);
    chk("dup_model_hits", 32'(h), 32'h8020);
    expect_key(h, 2, "dup");

    // clr during the 2nd active cycle
    key_hs(0, 0, 3, 3, 5);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_act1_pe_en", pe_en, 32'(model_hits(0, 0, 3, 3)));
    @(posedge clk); #1;
    clr = 1;
    @(negedge clk);
    chk("clr_cfg_ready", cfg_ready, 0);
    chk("clr_key_ready", key_ready, 0);
    @(posedge clk); #1;
    clr = 0;
    model_clear();
    @(negedge clk);
    chk("clr_pe_en", pe_en, 0);
    chk("clr_done", done, 0);
    chk("clr_busy", busy, 0);
    @(posedge clk); #1;
    run_key(0, 0, 3, 3, 2, "after_clr");

    // reset in the middle of an activation
    program_grid();
    key_hs(1, 1, 0, 0, 4);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstact_pe_en", pe_en, 32'h0020);
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    @(negedge clk);
    chk("rstact_pe_en_off", pe_en, 0);
    chk("rstact_done", done, 0);
    chk("rstact_busy", busy, 0);
    @(posedge clk); #1;
    run_key(1, 1, 0, 0, 1, "after_rst");

    // randomized traffic
    program_grid();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      run_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 4), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
